fetch_pipeline_ctrl: RTL

//  Consumer of the load-use stall request from hazard detection. Owns the PC register and the IF/DE

---
 rtl/fetch_ctrl_pkg.sv | 24 ++
 rtl/pc_register.sv | 40 ++++
 rtl/fetch_pipeline_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch pipeline controller.
package fetch_ctrl_pkg;

  localparam int unsigned XLEN_C     = 32;
  localparam logic [31:0] NOP_INST_C = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_STALL
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_INC,
    PC_HOLD,
    PC_LOAD
  } pc_sel_e;

  // Saturating 32-bit increment for the performance counters.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter flop: hold, load a redirect target, or step by 4 (wraps mod 2^XLEN).
// Reset is synchronous, active low.
module pc_register
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_C,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  pc_sel_e         sel_i,
  input  logic [XLEN-1:0] load_pc_i,
  output logic [XLEN-1:0] pc_o
);

  logic [XLEN-1:0] pc_d, pc_q;

  // Next-PC select.
  always_comb begin
    pc_d = pc_q;
    unique case (sel_i)
      PC_INC:  pc_d = pc_q + XLEN'(4);
      PC_HOLD: pc_d = pc_q;
      PC_LOAD: pc_d = load_pc_i;
      default: pc_d = pc_q;
    endcase
  end

  // PC state register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_pipeline_ctrl.sv
// Fetch pipeline controller: owns the PC and IF/DE register, applies load-use stall,
// branch-redirect flush and DE/EX bubble insertion.
// Optional feature macro: FETCH_PERF_CNT_EN enables saturating stall/flush counters.
module fetch_pipeline_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned     XLEN      = XLEN_C,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INST  = NOP_INST_C,
  parameter int unsigned     MAX_STALL = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hdu_stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic [31:0]     inst_if,
  output logic [XLEN-1:0] pc_if,
  output logic [31:0]     inst_de,
  output logic [XLEN-1:0] pc_de,
  output logic [XLEN-1:0] pc4_de,
  output logic            valid_de,
  output logic            bubble_ex,
  output logic            stall_err,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt
);

  localparam int unsigned ConsecW = $clog2(MAX_STALL + 2);
  localparam logic [ConsecW-1:0] ConsecMax = ConsecW'(MAX_STALL);

  fetch_state_e state_d, state_q;

  logic [31:0]      inst_de_d, inst_de_q;
  logic [XLEN-1:0]  pc_de_d, pc_de_q;
  logic             valid_de_d, valid_de_q;
  logic [ConsecW-1:0] consec_d, consec_q;
  logic             stall_err_d, stall_err_q;
  logic             stall_take;
  pc_sel_e          pc_sel;

  // A stall only counts when DE holds a real instruction and no redirect overrides it.
  assign stall_take = hdu_stall & valid_de_q & ~redirect_valid;
  assign bubble_ex  = redirect_valid | (hdu_stall & valid_de_q);

  pc_register #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .sel_i     (pc_sel),
    .load_pc_i (redirect_pc),
    .pc_o      (pc_if)
  );

  // FSM next state, PC select and IF/DE next values (redirect > stall > advance).
  always_comb begin
    state_d    = state_q;
    pc_sel     = PC_INC;
    inst_de_d  = inst_if;
    pc_de_d    = pc_if;
    valid_de_d = 1'b1;

    if (redirect_valid) begin
      pc_sel     = PC_LOAD;
      inst_de_d  = NOP_INST;
      pc_de_d    = pc_de_q;
      valid_de_d = 1'b0;
    end else if (stall_take) begin
      pc_sel     = PC_HOLD;
      inst_de_d  = inst_de_q;
      pc_de_d    = pc_de_q;
      valid_de_d = valid_de_q;
    end

    unique case (state_q)
      S_BOOT:  state_d = S_RUN;
      S_RUN:   state_d = stall_take ? S_STALL : S_RUN;
      S_STALL: state_d = stall_take ? S_STALL : S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  // Consecutive-stall tracking; error is sticky until reset.
  always_comb begin
    consec_d    = '0;
    stall_err_d = stall_err_q;
    if (stall_take) begin
      if (consec_q >= ConsecMax) begin
        consec_d    = consec_q;
        stall_err_d = 1'b1;
      end else begin
        consec_d = consec_q + ConsecW'(1);
      end
    end
  end

  // State, IF/DE and stall-tracking registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_BOOT;
      inst_de_q   <= NOP_INST;
      pc_de_q     <= '0;
      valid_de_q  <= 1'b0;
      consec_q    <= '0;
      stall_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      inst_de_q   <= inst_de_d;
      pc_de_q     <= pc_de_d;
      valid_de_q  <= valid_de_d;
      consec_q    <= consec_d;
      stall_err_q <= stall_err_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_take)     stall_cnt_q <= sat_inc32(stall_cnt_q);
      if (redirect_valid) flush_cnt_q <= sat_inc32(flush_cnt_q);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

  assign inst_de   = inst_de_q;
  assign pc_de     = pc_de_q;
  assign pc4_de    = pc_de_q + XLEN'(4);
  assign valid_de  = valid_de_q;
  assign stall_err = stall_err_q;

endmodule
